// File: rtl/barrett_pkg.sv
// Shared definitions for the Barrett setup stage and its consumer.
package barrett_pkg;

    // Control states of the mu precompute divider.
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } bmu_state_e;

    localparam int DATA_W_DEF = 64;

    // mu = floor(2^(2k)/m) peaks at 2^(k+1) when m = 2^(k-1), so two extra bits.
    function automatic int mu_width(input int dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/leading_one_detect.sv
// Bit length of m: 1 + index of the most-significant set bit, 0 when m is zero.
module leading_one_detect
    import barrett_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int K_W    = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] m,
    output logic [K_W-1:0]    k
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        k = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (m[i]) begin
                k = K_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/barrett_mu_precomp.sv
// Computes k = bitlen(m) and mu = floor(2^(2k)/m) with a one-bit-per-cycle
// restoring divider, for direct use by the Barrett reduction stage.
module barrett_mu_precomp
    import barrett_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int MU_W   = mu_width(DATA_W),
    parameter int CNT_W  = $clog2(2 * DATA_W + 2)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [DATA_W-1:0]            m_i,
    output logic                         busy_o,
    output logic                         valid_o,
    output logic                         err_o,
    output logic [$clog2(DATA_W+1)-1:0]  k_o,
    output logic [DATA_W-1:0]            m_o,
    output logic [MU_W-1:0]              mu_o
);

    localparam int K_W = $clog2(DATA_W + 1);
    localparam int R_W = DATA_W + 1;

    bmu_state_e        r_state;
    bmu_state_e        w_state_next;

    logic [DATA_W-1:0] r_m;
    logic [K_W-1:0]    r_k;
    logic [MU_W-1:0]   r_mu;
    logic [MU_W-1:0]   r_q;
    logic [R_W-1:0]    r_r;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;
    logic              r_err;

    logic [K_W-1:0]    w_k_det;
    logic              w_m_zero;
    logic              w_accept;
    logic              w_last;
    logic [CNT_W-1:0]  w_two_k;
    logic              w_d;
    logic [R_W-1:0]    w_r_shift;
    logic              w_qbit;
    logic [R_W-1:0]    w_r_next;
    logic [MU_W-1:0]   w_q_next;

    leading_one_detect #(
        .DATA_W (DATA_W),
        .K_W    (K_W)
    ) u_lod (
        .m (m_i),
        .k (w_k_det)
    );

    assign w_m_zero = (m_i == '0);
    // A start coinciding with the valid pulse is dropped; IDLE picks it up next cycle.
    assign w_accept = (r_state == IDLE) && start_i && !r_valid;
    assign w_last   = (r_cnt == '0);
    assign w_two_k  = CNT_W'({r_k, 1'b0});

    // One restoring-division step: dividend is 2^(2k), so only its top bit is set.
    always_comb begin
        w_d       = (r_cnt == w_two_k);
        // r < m always, so dropping r's top bit before the shift loses nothing.
        w_r_shift = R_W'({r_r, w_d});
        w_qbit    = (w_r_shift >= {1'b0, r_m});
        w_r_next  = w_qbit ? (w_r_shift - {1'b0, r_m}) : w_r_shift;
        w_q_next  = MU_W'({r_q, w_qbit});
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_m_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy_o  = (r_state != IDLE);
        valid_o = r_valid;
        err_o   = r_err;
        k_o     = r_k;
        m_o     = r_m;
        mu_o    = r_mu;
    end

    // Operand latch, divider registers and result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_m     <= '0;
            r_k     <= '0;
            r_mu    <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_m   <= m_i;
                        r_k   <= w_k_det;
                        r_err <= w_m_zero;
                        r_r   <= '0;
                        r_q   <= '0;
                        r_cnt <= CNT_W'({w_k_det, 1'b0});
                        if (w_m_zero) begin
                            r_mu <= '0;
                        end
                    end
                end
                CALC: begin
                    r_r <= w_r_next;
                    r_q <= w_q_next;
                    if (w_last) begin
                        r_mu <= w_q_next;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_mu_precomp.sv
// Scoreboard bench: requests push expected results, a negedge monitor checks them.
module tb_barrett_mu_precomp;

    localparam int DW   = 64;
    localparam int MUW  = DW + 2;

    typedef struct {
        logic [DW-1:0]  m;
        int             k;
        logic [MUW-1:0] mu;
        bit             err;
        longint         due;
    } exp_t;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           start_i;
    logic [DW-1:0]  m_i;
    logic           busy_o;
    logic           valid_o;
    logic           err_o;
    logic [6:0]     k_o;
    logic [DW-1:0]  m_o;
    logic [MUW-1:0] mu_o;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    exp_t   exp_q[$];
    exp_t   mon_e;

    barrett_mu_precomp #(
        .DATA_W (DW)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .m_i     (m_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .err_o   (err_o),
        .k_o     (k_o),
        .m_o     (m_o),
        .mu_o    (mu_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [129:0] act, input logic [129:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Bit length: smallest k with m < 2^k.
    function automatic int ref_k(input logic [DW-1:0] m);
        logic [DW:0] mm;
        int          k;
        mm = {1'b0, m};
        k  = 0;
        while ((mm >> k) != 0) k++;
        return k;
    endfunction

    function automatic logic [MUW-1:0] ref_mu(input logic [DW-1:0] m, input int k);
        logic [129:0] num;
        if (m == 0) return '0;
        num = 130'(1) << (2 * k);
        return MUW'(num / {66'd0, m});
    endfunction

    // Barrett reduction of x using the produced constant; true remainder after <=2 fixes.
    function automatic logic [129:0] barrett(input logic [63:0] x, input logic [63:0] m,
                                             input int k, input logic [MUW-1:0] mu);
        logic [129:0] q1, q3, r;
        q1 = {66'd0, x} >> (k - 1);
        q3 = (q1 * {64'd0, mu}) >> (k + 1);
        r  = {66'd0, x} - q3 * {66'd0, m};
        for (int i = 0; i < 2; i++) begin
            if (r >= {66'd0, m}) r = r - {66'd0, m};
        end
        return r;
    endfunction

    // Monitor: every valid pulse must match the oldest outstanding request.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got valid_o=1 (m_o=0x%0h), expected no result", m_o);
            end else begin
                logic [63:0] x;
                mon_e = exp_q.pop_front();
                check("k_o", 130'(k_o), 130'(mon_e.k));
                check("m_o", 130'(m_o), 130'(mon_e.m));
                check("mu_o", 130'(mu_o), 130'(mon_e.mu));
                check("err_o", 130'(err_o), 130'(mon_e.err));
                check("latency", 130'(cyc), 130'(mon_e.due));
                if (!mon_e.err && mon_e.m >= 2 && mon_e.m < 64'h1_0000_0000) begin
                    x = {$urandom, $urandom} % (mon_e.m * mon_e.m);
                    check("barrett_rem", barrett(x, mon_e.m, mon_e.k, mu_o),
                          130'(x % mon_e.m));
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 130'(busy_o), 130'(0));
        check({tag, "_valid"}, 130'(valid_o), 130'(0));
        check({tag, "_err"}, 130'(err_o), 130'(0));
        check({tag, "_k"}, 130'(k_o), 130'(0));
        check({tag, "_m"}, 130'(m_o), 130'(0));
        check({tag, "_mu"}, 130'(mu_o), 130'(0));
    endtask

    // Pulse start for one cycle; an accepted request records its expected result.
    task automatic issue(input logic [DW-1:0] m, input bit accept);
        exp_t e;
        @(negedge clk_i);
        m_i     = m;
        start_i = 1'b1;
        if (accept) begin
            e.m   = m;
            e.k   = ref_k(m);
            e.mu  = ref_mu(m, e.k);
            e.err = (m == 0);
            e.due = cyc + 1 + ((m == 0) ? 1 : 2 * e.k + 2);
            exp_q.push_back(e);
        end
        @(negedge clk_i);
        start_i = 1'b0;
        if (accept) check("busy_after_start", 130'(busy_o), 130'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk_i);
    endtask

    initial begin
        logic [63:0] dir [7];
        logic [63:0] rm;
        bit          seen;
        dir = '{64'd5, 64'd1, 64'd7, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd5};

        rst_i   = 1'b1;
        start_i = 1'b0;
        m_i     = '0;
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        foreach (dir[i]) begin
            issue(dir[i], 1'b1);
            drain();
        end

        // Start while busy and start on the valid cycle are both dropped.
        issue(64'd5, 1'b1);
        repeat (3) @(negedge clk_i);
        issue(64'd9, 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk_i);
            if (valid_o) begin
                seen    = 1'b1;
                m_i     = 64'd7;
                start_i = 1'b1;
                @(negedge clk_i);
                start_i = 1'b0;
            end
        end
        check("ignore_valid_seen", 130'(seen), 130'(1));
        repeat (20) @(negedge clk_i);
        check("ignore_busy", 130'(busy_o), 130'(0));
        check("ignore_mu_held", 130'(mu_o), 130'(12));
        check("ignore_m_held", 130'(m_o), 130'(5));
        exp_q.delete();

        // Reset mid-calculation aborts with no result.
        issue(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        repeat (10) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_zero("mid_reset");
        exp_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (150) @(negedge clk_i);
        issue(64'd5, 1'b1);
        drain();

        for (int i = 0; i < 100; i++) begin
            rm = 64'($urandom_range(32'hFFFF_FFFF, 2));
            issue(rm, 1'b1);
            drain();
        end
        for (int i = 0; i < 10; i++) begin
            rm = {$urandom, $urandom};
            if (rm == 0) rm = 64'd3;
            issue(rm, 1'b1);
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
